// File: rtl/fifo_burst_reader.sv
// Read-side burst engine for the synchronous FIFO: pulls burst_len words and forwards
// them on a valid/ready stream, hiding the FIFO's one-cycle read latency in a 2-entry buffer.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  Read_enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [1:0]            state_dbg
);

    // Stream handshake: a beat transfers on a rising edge where m_valid && m_ready;
    // m_valid, m_data and m_last hold steady while m_valid && !m_ready.
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                state, state_nxt;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  to_deliver;
    logic                  inflight;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic                  pop;
    logic [2:0]            credit_used;

    assign pop         = m_valid && m_ready;
    // Slots that will be held after this edge: buffered words plus the word in flight.
    assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign m_valid   = (occ != 2'd0);
    assign m_data    = buf0;
    assign m_last    = m_valid && (to_deliver == LEN_WIDTH'(1));
    assign state_dbg = state;

    always_comb begin
        state_nxt   = state;
        Read_enable = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (burst_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                Read_enable = !reset && !empty && (remaining != '0) && (credit_used < 3'd2);
                if (Read_enable && (remaining == LEN_WIDTH'(1))) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && (to_deliver == LEN_WIDTH'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            to_deliver <= '0;
            inflight   <= 1'b0;
            occ        <= 2'd0;
            buf0       <= '0;
            buf1       <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= Read_enable;
            if (state == IDLE && start) begin
                remaining  <= burst_len;
                to_deliver <= burst_len;
            end else begin
                if (Read_enable) remaining <= remaining - LEN_WIDTH'(1);
                if (pop)         to_deliver <= to_deliver - LEN_WIDTH'(1);
            end
            // buf0 is the head; a word arriving from the FIFO lands behind whatever survives the pop.
            unique case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= data_out;
                    else             buf1 <= data_out;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= data_out;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= data_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT; a per-cycle monitor
// checks every output against a transaction-level model, plus directed literal scenarios.
module tb_fifo_burst_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [5:0] burst_len = '0;
    logic       empty = 1'b1;
    logic [7:0] data_out = '0;
    logic       m_ready = 1'b0;
    logic       busy, done, Read_enable, m_valid, m_last;
    logic [7:0] m_data;
    logic [1:0] state_dbg;

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       clr = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         re_cyc_q[$];
    int         beat_cyc_q[$];
    logic [7:0] beat_data_q[$];
    logic       beat_last_q[$];
    int         done_cyc_q[$];
    int         start_cyc_q[$];
    int         tot_busy = 0;

    fifo_burst_reader dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .Read_enable(Read_enable), .empty(empty),
        .data_out(data_out), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_ready(m_ready), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: one word of read latency, writes visible to empty on the next cycle.
    always @(posedge clk) begin
        if (clr) fifo_q.delete();
        if (Read_enable && fifo_q.size() > 0) data_out <= fifo_q.pop_front();
        else                                  data_out <= 8'($urandom);
        if (wr_en) fifo_q.push_back(wr_data);
        empty <= (fifo_q.size() == 0);
    end

    // Transaction-level model of the burst: what must be busy/done, how many reads remain,
    // how many beats remain, and which words are owed downstream.
    logic mb = 1'b0, md = 1'b0, rd_prev = 1'b0, stall_prev = 1'b0;
    int   reads_left = 0, beats_left = 0, rd_cnt = 0, bt_cnt = 0;
    logic [7:0] prev_data = '0;

    always @(negedge clk) begin
        int   outstanding;
        int   occ_m;
        logic pop_m;
        logic re_exp;
        if (reset) begin
            chk("re_in_reset", Read_enable, 1'b0);
            mb = 1'b0; md = 1'b0; reads_left = 0; beats_left = 0;
            rd_cnt = 0; rd_prev = 1'b0; bt_cnt = 0; stall_prev = 1'b0;
            exp_q.delete();
        end else begin
            if (busy) tot_busy++;
            if (done) done_cyc_q.push_back(cyc);
            if (rd_prev) exp_q.push_back(data_out);
            pop_m       = m_valid && m_ready;
            outstanding = rd_cnt - bt_cnt;
            occ_m       = outstanding - int'(rd_prev);
            chk("busy", busy, mb);
            chk("done", done, md);
            chk("m_valid", m_valid, occ_m > 0);
            re_exp = mb && !md && reads_left > 0 && !empty && (outstanding - int'(pop_m)) < 2;
            chk("read_enable", Read_enable, re_exp);
            chk("m_last", m_last, m_valid && beats_left == 1);
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, prev_data);
            end
            if (pop_m) begin
                chk("beat_avail", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) chk("beat_data", m_data, exp_q.pop_front());
                bt_cnt++;
                beats_left--;
                beat_cyc_q.push_back(cyc);
                beat_data_q.push_back(m_data);
                beat_last_q.push_back(m_last);
            end
            if (Read_enable) begin
                reads_left--;
                re_cyc_q.push_back(cyc);
            end
            rd_cnt  = rd_cnt + int'(Read_enable);
            rd_prev = Read_enable;
            if (md) begin
                mb = 1'b0; md = 1'b0; rd_cnt = 0; bt_cnt = 0; rd_prev = 1'b0;
            end else if (mb) begin
                if (pop_m && beats_left == 0) md = 1'b1;
            end else if (start) begin
                start_cyc_q.push_back(cyc);
                mb = 1'b1;
                if (burst_len == 0) md = 1'b1;
                else begin
                    reads_left = int'(burst_len);
                    beats_left = int'(burst_len);
                end
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic preload(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = base + 8'(i);
            step();
        end
        wr_en = 1'b0;
        step();
    endtask

    task automatic clear_fifo();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
    endtask

    task automatic pulse_start(input int len);
        start     = 1'b1;
        burst_len = 6'(len);
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cyc_q.size() == d0 && n < budget) begin
            step();
            n++;
        end
        chk("done_seen", done_cyc_q.size(), d0 + 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int s0, r0, b0, d0, bz, nread, len, pre, pushed, n;
        steps(3);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_re", Read_enable, 1'b0);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_data", m_data, 8'h00);
        chk("rst_last", m_last, 1'b0);
        reset = 1'b0;
        step();

        // Basic burst
        preload(8'hA0, 4);
        m_ready = 1'b1;
        s0 = start_cyc_q.size(); r0 = re_cyc_q.size(); b0 = beat_cyc_q.size(); d0 = done_cyc_q.size();
        pulse_start(4);
        wait_done(d0, 50);
        step();
        chk("b_re_count", re_cyc_q.size() - r0, 4);
        for (int k = 0; k < 4; k++) begin
            chk("b_re_cycle", re_cyc_q[r0 + k], start_cyc_q[s0] + 1 + k);
            chk("b_beat_cycle", beat_cyc_q[b0 + k], start_cyc_q[s0] + 3 + k);
            chk("b_beat_data", beat_data_q[b0 + k], 8'hA0 + 8'(k));
            chk("b_beat_last", beat_last_q[b0 + k], k == 3);
        end
        chk("b_done_cycle", done_cyc_q[d0], start_cyc_q[s0] + 7);
        chk("b_busy_after", busy, 1'b0);

        // Zero-length burst
        clear_fifo();
        preload(8'h30, 3);
        s0 = start_cyc_q.size(); r0 = re_cyc_q.size(); b0 = beat_cyc_q.size(); d0 = done_cyc_q.size();
        bz = tot_busy;
        pulse_start(0);
        wait_done(d0, 10);
        steps(4);
        chk("z_re_count", re_cyc_q.size() - r0, 0);
        chk("z_beats", beat_cyc_q.size() - b0, 0);
        chk("z_done_cycle", done_cyc_q[d0], start_cyc_q[s0] + 1);
        chk("z_busy_cycles", tot_busy - bz, 1);
        chk("z_fifo_left", fifo_q.size(), 3);

        // Backpressure
        clear_fifo();
        preload(8'h10, 6);
        m_ready = 1'b0;
        r0 = re_cyc_q.size(); b0 = beat_cyc_q.size(); d0 = done_cyc_q.size();
        pulse_start(6);
        steps(10);
        chk("bp_re_count", re_cyc_q.size() - r0, 2);
        chk("bp_held_valid", m_valid, 1'b1);
        chk("bp_held_data", m_data, 8'h10);
        m_ready = 1'b1;
        wait_done(d0, 50);
        chk("bp_beats", beat_cyc_q.size() - b0, 6);
        for (int k = 0; k < 6; k++) chk("bp_data", beat_data_q[b0 + k], 8'h10 + 8'(k));
        chk("bp_no_gaps", beat_cyc_q[b0 + 5] - beat_cyc_q[b0], 5);
        chk("bp_last5", beat_last_q[b0 + 5], 1'b1);
        chk("bp_last4", beat_last_q[b0 + 4], 1'b0);

        // FIFO runs dry
        clear_fifo();
        preload(8'h50, 2);
        r0 = re_cyc_q.size(); b0 = beat_cyc_q.size(); d0 = done_cyc_q.size();
        pulse_start(5);
        steps(10);
        chk("dry_beats", beat_cyc_q.size() - b0, 2);
        chk("dry_re_count", re_cyc_q.size() - r0, 2);
        chk("dry_busy", busy, 1'b1);
        chk("dry_re_low", Read_enable, 1'b0);
        preload(8'h52, 3);
        wait_done(d0, 50);
        step();
        chk("dry_total_beats", beat_cyc_q.size() - b0, 5);
        chk("dry_last_data", beat_data_q[b0 + 4], 8'h54);
        chk("dry_last_flag", beat_last_q[b0 + 4], 1'b1);
        chk("dry_done_count", done_cyc_q.size() - d0, 1);

        // Reset mid-burst
        clear_fifo();
        preload(8'h40, 12);
        r0 = re_cyc_q.size(); b0 = beat_cyc_q.size();
        pulse_start(8);
        n = 0;
        while (beat_cyc_q.size() < b0 + 3 && n < 50) begin
            step();
            n++;
        end
        chk("rm_three_beats", beat_cyc_q.size() >= b0 + 3, 1'b1);
        reset = 1'b1;
        nread = re_cyc_q.size() - r0;
        step();
        reset = 1'b0;
        chk("rm_busy", busy, 1'b0);
        chk("rm_valid", m_valid, 1'b0);
        chk("rm_re", Read_enable, 1'b0);
        chk("rm_done", done, 1'b0);
        step();
        b0 = beat_cyc_q.size(); d0 = done_cyc_q.size();
        pulse_start(2);
        wait_done(d0, 30);
        chk("rm_beats", beat_cyc_q.size() - b0, 2);
        chk("rm_data0", beat_data_q[b0], 8'(8'h40 + nread));
        chk("rm_data1", beat_data_q[b0 + 1], 8'(8'h41 + nread));

        // Start while busy
        clear_fifo();
        preload(8'h60, 8);
        r0 = re_cyc_q.size(); b0 = beat_cyc_q.size(); d0 = done_cyc_q.size();
        pulse_start(4);
        step();
        pulse_start(7);
        wait_done(d0, 30);
        steps(5);
        chk("sb_beats", beat_cyc_q.size() - b0, 4);
        chk("sb_re_count", re_cyc_q.size() - r0, 4);
        chk("sb_done_count", done_cyc_q.size() - d0, 1);
        chk("sb_fifo_left", fifo_q.size(), 4);

        // Randomized bursts: random lengths, FIFO trickle-fill, random backpressure, stray starts
        for (int b = 0; b < 30; b++) begin
            clear_fifo();
            len = $urandom_range(0, 32);
            pre = $urandom_range(0, len);
            b0  = beat_cyc_q.size(); d0 = done_cyc_q.size();
            preload(8'($urandom), pre);
            pushed = pre;
            m_ready = 1'($urandom_range(0, 1));
            pulse_start(len);
            n = 0;
            while (done_cyc_q.size() == d0 && n < 2000) begin
                m_ready   = ($urandom_range(0, 3) != 0);
                start     = ($urandom_range(0, 15) == 0);
                burst_len = 6'($urandom_range(0, 32));
                wr_en     = 1'b0;
                if (pushed < len && $urandom_range(0, 1) == 1) begin
                    wr_en   = 1'b1;
                    wr_data = 8'($urandom);
                    pushed++;
                end
                step();
                n++;
            end
            start = 1'b0;
            wr_en = 1'b0;
            chk("rnd_done_seen", done_cyc_q.size(), d0 + 1);
            chk("rnd_beats", beat_cyc_q.size() - b0, len);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side engine for the synchronous FIFO. On a `start` command it pulls exactly `burst_len` words out of the FIFO through its `Read_enable`/`empty`/`data_out` port.
- Forwards those words, in order, on a valid/ready stream with a last-beat marker.
- Absorbs the FIFO's one-cycle read latency with a 2-entry output buffer. It sustains 1 word/cycle under no backpressure and never loses data under backpressure.

Parameters:
- DATA_WIDTH, 8, FIFO word width.
- ADDR_WIDTH, 5, FIFO address width (FIFO depth = 2**ADDR_WIDTH).
- LEN_WIDTH, ADDR_WIDTH+1, width of the burst length (0..2**ADDR_WIDTH).

Ports:
- clk  input  1  Single clock for the whole block.
- reset  input  1  Synchronous reset, active-high.
- start  input  1  Burst request; accepted only in IDLE.
- burst_len  input  LEN_WIDTH  Words to read; sampled with an accepted `start`.
- busy  output  1  High from the cycle after `start` is accepted until `done`, inclusive.
- done  output  1  One-cycle pulse when the burst has completed.
- Read_enable  output  1  Read strobe to the FIFO.
- empty  input  1  FIFO empty flag.
- data_out  input  DATA_WIDTH  FIFO read data; valid the cycle after the `Read_enable` cycle.
- m_valid  output  1  Output word valid.
- m_data  output  DATA_WIDTH  Output word.
- m_last  output  1  High with the final word of the burst.
- m_ready  input  1  Downstream accept; a beat transfers when `m_valid && m_ready` at the rising edge.

Behaviour:
- Reset values: `busy`=0, `done`=0, `Read_enable`=0, `m_valid`=0, `m_data`=0, `m_last`=0; state=IDLE; all counters and buffer occupancy cleared.
- Internal state:
  - `remaining`: reads still to issue.
  - `inflight`: 0/1, a read issued last cycle.
  - `occ`: 0..2, buffer occupancy.
  - `to_deliver`: beats still to hand downstream.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - `start`=1 with `burst_len`>0: latch `remaining`=`to_deliver`=`burst_len`, go to RUN.
  - `start`=1 with `burst_len`=0: go to DONE, issuing no reads.
- RUN:
  - `Read_enable` = `!empty && remaining!=0 && (occ + inflight - (m_valid && m_ready)) < 2`. This is combinational from state, `empty` and `m_ready`.
  - Each read decrements `remaining`. When the last read issues (`remaining` goes 1->0), go to FLUSH.
- FLUSH: no reads. When `to_deliver` reaches 0 (final beat handshaken), go to DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=1 in the same cycle, then IDLE.
- `busy`: 1 in RUN, FLUSH and DONE.
- `Read_enable` is never asserted when `empty`=1, in IDLE/FLUSH/DONE, or while `reset`=1.
- Data capture:
  - The word on `data_out` in the cycle after a read (`inflight`=1) is written into the buffer tail.
  - The buffer head drives `m_data`, with `m_valid` = `occ`>0.
  - Simultaneous capture and pop keeps `occ` unchanged and preserves order.
  - The buffer never overflows; the credit rule above guarantees `occ` <= 2.
- Latency: the first `Read_enable` is the cycle after `start` is sampled. The first `m_valid` comes 2 cycles after the first `Read_enable` cycle.
- Throughput: with `m_ready`=1 and FIFO non-empty, 1 read/cycle and 1 beat/cycle.
- Stall rules:
  - `m_data`, `m_last` and `m_valid` stay stable while `m_valid && !m_ready`.
  - `m_valid` never drops without a handshake.
- `m_last` = `m_valid` and the head word is beat number `burst_len` (i.e. `to_deliver`==1).
- FIFO empty mid-burst: reads pause, state stays RUN, and reads resume as soon as `empty`=0. There is no timeout.
- `start` while `busy`=1 is ignored; `burst_len` is not re-sampled.
- Reset mid-burst: on the next edge every output takes its reset value. Words already read from the FIFO and not yet delivered are discarded. The next `start` behaves exactly as after power-up.

Test Plan:
- **Basic burst:** FIFO preloaded 0xA0..0xA3, `m_ready`=1, `start` with `burst_len`=4.
  - `Read_enable` is high 4 consecutive cycles starting the cycle after `start`.
  - 4 beats 0xA0..0xA3 arrive on consecutive cycles, the first 2 cycles after the first `Read_enable`.
  - `m_last` is high only on 0xA3; `done` pulses the cycle after the 0xA3 handshake; `busy` then drops.
- **Zero-length burst:** `start` with `burst_len`=0, FIFO holding 3 words.
  - No `Read_enable` ever asserts and no `m_valid`.
  - `done` and `busy` are both high for exactly 1 cycle, 1 cycle after `start`; the FIFO still holds 3 words.
- **Backpressure:** FIFO holds 0x10..0x15, `burst_len`=6, `m_ready`=0.
  - At most 2 `Read_enable` cycles occur; `m_data`=0x10 is held stable.
  - Release `m_ready`=1: 0x10..0x15 are delivered in order with no gaps after the first, and `m_last` is on 0x15.
- **FIFO runs dry:** FIFO holds 2 words, `burst_len`=5.
  - 2 beats are delivered, then `empty`=1 → `Read_enable` stays low and `busy` stays high.
  - Write 3 more words: reads resume, 5 beats total, `m_last` on the 5th, one `done`.
- **Reset mid-burst:** `burst_len`=8, assert `reset` after the 3rd beat.
  - Next cycle: `busy`=`m_valid`=`Read_enable`=`done`=0.
  - A new `start` with `burst_len`=2 delivers the next 2 FIFO words with no stale data.
- **Start while busy:** during a `burst_len`=4 burst, pulse `start` with `burst_len`=7.
  - Exactly 4 beats are delivered and 1 `done` occurs; no extra reads are issued.
